// File: rtl/uart_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_byte_tx
//   Serial transmit stage behind the RGB byte serializer. Each one-cycle
//   data_in_valid strobe presents a byte that is shifted out on tx as a UART
//   frame (start bit, 8 data bits LSB first, stop bit). A one-byte holding
//   buffer absorbs a strobe that arrives while a frame is in flight; a
//   further strobe while the buffer is full is dropped and flagged.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> an even-parity bit is sent between the data and stop bits
//     undefined -> plain 8N1 framing
//
// Parameters
//   BAUD_CNT_MAX   clock cycles per bit period (>= 2)
//
// Ports
//   sys_clk        system clock, rising edge
//   sys_rst        synchronous active-high reset
//   data_in        byte to send, sampled only with data_in_valid
//   data_in_valid  one-cycle strobe presenting data_in
//   tx             serial line, idles high
//   tx_busy        frame on the line or holding buffer occupied
//   tx_done        one-cycle pulse when a stop bit completes
//   overrun        one-cycle pulse when a strobed byte is dropped
// ---------------------------------------------------------------------------
module uart_byte_tx #(
    parameter int unsigned BAUD_CNT_MAX = 5208
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       overrun
);

    localparam int unsigned CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shift_q;
    logic [7:0]       shift_nxt;
    logic [7:0]       hold_q;
    logic [7:0]       hold_nxt;
    logic             hold_full;
    logic             hold_full_nxt;
    logic             tx_nxt;
    logic             tx_busy_nxt;
    logic             tx_done_nxt;
    logic             overrun_nxt;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
    logic             parity_nxt;
`endif

    logic bit_end;
    logic stop_end;

    // Last cycle of the current bit period, and of the stop bit in particular
    assign bit_end  = (baud_cnt == CNT_LAST);
    assign stop_end = (state == S_STOP) && bit_end;

    // State and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_q   <= shift_nxt;
            hold_q    <= hold_nxt;
            hold_full <= hold_full_nxt;
            tx        <= tx_nxt;
            tx_busy   <= tx_busy_nxt;
            tx_done   <= tx_done_nxt;
            overrun   <= overrun_nxt;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_nxt;
`endif
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt + CNT_W'(1);
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift_q;
        hold_nxt      = hold_q;
        hold_full_nxt = hold_full;
        tx_nxt        = tx;
        tx_done_nxt   = 1'b0;
        overrun_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt    = parity_q;
`endif

        case (state)
            S_IDLE: begin
                baud_cnt_nxt = '0;
                tx_nxt       = 1'b1;
                if (data_in_valid) begin
                    shift_nxt = data_in;
`ifdef UART_TX_PARITY_EN
                    parity_nxt = ^data_in;
`endif
                    state_nxt = S_START;
                    tx_nxt    = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    state_nxt    = S_DATA;
                    tx_nxt       = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = parity_q;
`else
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        // shift_q[0] is always the bit currently on the line
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = {1'b0, shift_q[7:1]};
                        tx_nxt      = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = S_STOP;
                    tx_nxt       = 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    tx_done_nxt  = 1'b1;
                    if (hold_full) begin
                        // Buffered byte goes out with no idle gap
                        shift_nxt     = hold_q;
`ifdef UART_TX_PARITY_EN
                        parity_nxt    = ^hold_q;
`endif
                        hold_full_nxt = 1'b0;
                        state_nxt     = S_START;
                        tx_nxt        = 1'b0;
                    end else if (data_in_valid) begin
                        // Strobe on the stop-end cycle starts the next frame directly
                        shift_nxt = data_in;
`ifdef UART_TX_PARITY_EN
                        parity_nxt = ^data_in;
`endif
                        state_nxt = S_START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                baud_cnt_nxt = '0;
                tx_nxt       = 1'b1;
            end
        endcase

        // Strobe during a frame: fill the holding buffer or flag the drop.
        // On the stop-end cycle the buffer is being drained, so a strobe
        // refills it instead of overrunning; with the buffer empty the
        // strobe was already consumed as the next frame above.
        if (data_in_valid && (state != S_IDLE) && !(stop_end && !hold_full)) begin
            if (!hold_full || stop_end) begin
                hold_nxt      = data_in;
                hold_full_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end

        tx_busy_nxt = (state_nxt != S_IDLE) || hold_full_nxt;
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_tx
//   Directed bench for uart_byte_tx at BAUD_CNT_MAX = 16. Inputs change 1 ns
//   after a rising edge and outputs are sampled at the same point, so every
//   sample reflects the registers updated by the preceding edge.
// ---------------------------------------------------------------------------
module tb_uart_byte_tx;

    localparam int unsigned BAUD = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic       overrun;

    int n_checks;
    int n_fail;

    uart_byte_tx #(
        .BAUD_CNT_MAX(BAUD)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .overrun      (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Present one byte for exactly one clock edge
    task automatic strobe(input logic [7:0] b);
        data_in       = b;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    // Check one full frame of byte b, starting one sample after the edge that
    // launched it. inj1/inj2 are sample indices after which a strobe is
    // presented (edge index = sample + 1); ovr_at is the sample where overrun
    // must read 1. A negative index disables the item.
    task automatic run_frame(input logic [7:0] b,
                             input int inj1, input logic [7:0] ib1,
                             input int inj2, input logic [7:0] ib2,
                             input int ovr_at);
        logic exp_bit;
        int   j;
        for (int i = 0; i < NBITS; i++) begin
            if (i == 0)
                exp_bit = 1'b0;
            else if (i <= 8)
                exp_bit = b[i-1];
`ifdef UART_TX_PARITY_EN
            else if (i == 9)
                exp_bit = ^b;
`endif
            else
                exp_bit = 1'b1;
            for (int c = 0; c < int'(BAUD); c++) begin
                j = i * int'(BAUD) + c;
                chk("frame_tx", tx, exp_bit);
                chk("frame_busy", tx_busy, 1'b1);
                chk("frame_overrun", overrun, (j == ovr_at));
                if (j != 0)
                    chk("frame_done_low", tx_done, 1'b0);
                if (j == inj1) begin
                    data_in       = ib1;
                    data_in_valid = 1'b1;
                end
                if (j == inj2) begin
                    data_in       = ib2;
                    data_in_valid = 1'b1;
                end
                tick();
                data_in_valid = 1'b0;
            end
        end
    endtask

    // Last frame of a burst: done pulses, line returns idle, busy drops
    task automatic end_idle(input string tag);
        chk({tag, "_done"}, tx_done, 1'b1);
        chk({tag, "_busy"}, tx_busy, 1'b0);
        chk({tag, "_tx"}, tx, 1'b1);
        tick();
        chk({tag, "_done_clear"}, tx_done, 1'b0);
    endtask

    // Frame followed immediately by another: done pulses, busy stays high
    task automatic end_chain(input string tag);
        chk({tag, "_done"}, tx_done, 1'b1);
        chk({tag, "_busy"}, tx_busy, 1'b1);
        chk({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        sys_rst       = 1'b1;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        tick();
        tick();
        tick();

        // Reset values
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        sys_rst = 1'b0;
        tick();
        chk("idle_tx", tx, 1'b1);
        chk("idle_busy", tx_busy, 1'b0);

        // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1
        strobe(8'hA5);
        run_frame(8'hA5, -1, 8'h00, -1, 8'h00, -1);
        end_idle("a5_end");

        // 0x3C then 0xC3 twenty cycles later: back-to-back, no overrun
        strobe(8'h3C);
        run_frame(8'h3C, 19, 8'hC3, -1, 8'h00, -1);
        end_chain("b2b_first");
        run_frame(8'hC3, -1, 8'h00, -1, 8'h00, -1);
        end_idle("b2b_second");

        // Strobes at 0, 5, 10: 0x33 dropped with overrun at cycle 10
        strobe(8'h11);
        run_frame(8'h11, 4, 8'h22, 9, 8'h33, 10);
        end_chain("ovr_first");
        run_frame(8'h22, -1, 8'h00, -1, 8'h00, -1);
        end_idle("ovr_second");
        for (int k = 0; k < 40; k++) begin
            chk("ovr_no_third_tx", tx, 1'b1);
            chk("ovr_no_third_busy", tx_busy, 1'b0);
            tick();
        end

        // 0x55 strobed exactly on the stop-end edge with the buffer empty
        strobe(8'h0F);
        run_frame(8'h0F, int'(BAUD) * NBITS - 1, 8'h55, -1, 8'h00, -1);
        end_chain("stopend_first");
        run_frame(8'h55, -1, 8'h00, -1, 8'h00, -1);
        end_idle("stopend_second");

        // Reset at cycle 70 of a frame aborts it; a later frame is clean
        strobe(8'h96);
        for (int k = 0; k < 69; k++)
            tick();
        chk("abort_pre_busy", tx_busy, 1'b1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", tx_busy, 1'b0);
        chk("abort_done", tx_done, 1'b0);
        chk("abort_overrun", overrun, 1'b0);
        for (int k = 0; k < 20; k++) begin
            chk("abort_idle_tx", tx, 1'b1);
            tick();
        end
        strobe(8'h5A);
        run_frame(8'h5A, -1, 8'h00, -1, 8'h00, -1);
        end_idle("abort_after");

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones -> parity 1; 0x03 has two -> parity 0
        strobe(8'h07);
        run_frame(8'h07, -1, 8'h00, -1, 8'h00, -1);
        end_idle("par_07");
        strobe(8'h03);
        run_frame(8'h03, -1, 8'h00, -1, 8'h00, -1);
        end_idle("par_03");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
